fir_sparse_tdm_q15: RTL and testbench
=====================================

Name: fir_sparse_tdm_q15

Overview:
Next-generation pruned Q15 FIR. It supports CH time-multiplexed channels, each with its own circular delay line of L samples. All channels share a run-time-loadable sparse table of NZ (tap index, coefficient) pairs and a single multiply-accumulate unit. Output is rounded and saturated to OUT_W with a saturation flag, and both ends use valid/ready handshakes. It sits in the 2-D filter datapath as the row/column 1-D engine.

Parameters:
L, 31, full filter length; delay-line depth per channel
NZ, 24, number of non-zero (stored) taps
CH, 2, number of independent channels
IN_W, 16, input sample width, signed Q15
COEF_W, 16, coefficient width, signed Q15
ACC_W, 40, accumulator width
OUT_W, 16, output width, signed
FRAC, 15, right-shift applied to accumulator before saturation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data_in  in  IN_W  signed input sample
data_in_ch  in  clog2(CH)  channel of data_in
data_in_valid  in  1  sample present
data_in_ready  out  1  block can accept a sample
data_out  out  OUT_W  rounded, saturated result
data_out_ch  out  clog2(CH)  channel of data_out
data_out_sat  out  1  data_out was clipped
data_out_valid  out  1  result present
data_out_ready  in  1  downstream accepts result
cfg_we  in  1  coefficient-table write strobe
cfg_addr  in  clog2(NZ)  table entry
cfg_tap  in  clog2(L)  tap index (delay) for that entry
cfg_coef  in  COEF_W  signed coefficient
cfg_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 except data_in_ready=1.
  - All delay lines, write pointers, accumulator, tap and coef tables cleared to 0.
  - Reset mid-operation aborts the computation; no output is produced for the aborted sample.
- FSM states:
  - IDLE: data_in_ready=1. On data_in_valid, accept (edge E0):
    - write data_in at wr_ptr[ch], then advance wr_ptr[ch] modulo L (wrap L-1 -> 0);
    - latch ch; acc=0; k=0; go to MAC.
  - MAC: one entry per edge (E1..ENZ).
    - acc += sext(x[ch][(newest_ptr - tap[k]) mod L] * coef[k]).
    - Product is a full IN_W+COEF_W signed value, sign-extended to ACC_W; acc wraps in ACC_W with no overflow detection.
    - After k=NZ-1, go to ROUND.
  - ROUND: edge E(NZ+1).
    - r = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
    - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - Register data_out, data_out_ch, data_out_sat; data_out_valid=1; go to OUT.
  - OUT: hold all outputs stable while data_out_ready=0.
    - On data_out_ready=1: data_out_valid=0 at next edge; go to IDLE.
- Latency and throughput:
  - Latency from the accept edge to data_out_valid high is NZ+1 cycles.
  - Throughput is at most one sample per NZ+3 cycles with no backpressure.
  - data_in_ready=0 in MAC/ROUND/OUT.
- Data_out_ready=1 in OUT and data_in_valid in the same cycle: the input is NOT accepted that cycle; it is accepted in IDLE on the next cycle.
- data_in_ch >= CH on accept: sample dropped, no state change, cfg_err not asserted.
- Configuration:
  - cfg_we is honoured only in IDLE.
  - cfg_we in other states, or cfg_tap >= L, or cfg_addr >= NZ: write ignored, cfg_err pulses 1 cycle.
  - A cfg write and an input accept in the same IDLE cycle: the write takes effect first, so the new sample uses the updated table.
- Duplicate tap indices are legal; their contributions add.
- Unused entries keep coef=0 and contribute nothing.
- Channels are fully independent: a sample on channel A never reads channel B's delay line.

Decomposition:
- Package fir_pkg holds:
  - width/helper functions (clog2 wrapper, sign-extend);
  - FSM state enum constants IDLE/MAC/ROUND/OUT;
  - rounding constant ROUND_HALF = 1 << (FRAC-1).
- Sub-module fir_round_sat: combinational round-shift-saturate, ACC_W -> OUT_W plus sat flag. It is reused by the 2-D top.

Test Plan:
- Impulse: cfg entry0 = (tap 0, 0x7FFF), others 0; send 0x4000 on ch0 -> data_out=16384, sat=0, valid exactly NZ+1 cycles after accept; then send 0x0000 -> 0.
- Delay/wrap: entry0 = (tap 30, 0x7FFF); send 0x4000 followed by 30 zeros -> outputs 0 until the 31st sample yields 16384. Send 31 more to verify pointer wrap.
- Saturation/sign: entries (0, 0x7FFF) and (1, 0x7FFF); send 0x7FFF, 0x7FFF -> second output 32767, sat=1. Then send 0x8000, 0x8000 -> -32768, sat=1.
- Channel isolation: interleave ch0=0x4000 and ch1=0x2000 with the impulse table -> data_out_ch matches the input channel; values 16384 and 8192; no cross-talk at tap 1.
- Backpressure: hold data_out_ready=0 for 10 cycles -> data_out and data_out_valid stable, data_in_ready=0, and the offered sample is not accepted until after the handshake.
- Reset/config errors: assert rst_n=0 at MAC k=5 -> all outputs 0 at once, no output after release. cfg_we during MAC, or cfg_tap=31 -> cfg_err pulses and the table is unchanged.

Source files
------------

// File: rtl/fir_sparse_tdm_q15_pkg.sv
// Shared constants, FSM encoding and small helpers for the sparse TDM Q15 FIR.
package fir_pkg;

    // Default geometry; the top-level parameters take these as their defaults.
    localparam int FIR_L      = 31;
    localparam int FIR_NZ     = 24;
    localparam int FIR_CH     = 2;
    localparam int FIR_IN_W   = 16;
    localparam int FIR_COEF_W = 16;
    localparam int FIR_ACC_W  = 40;
    localparam int FIR_OUT_W  = 16;
    localparam int FIR_FRAC   = 15;
    localparam int FIR_PROD_W = FIR_IN_W + FIR_COEF_W;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

    // Index width for n entries; never returns zero so a 1-entry table still has a port bit.
    function automatic int fir_clog2(input int n);
        int r;
        if (n <= 1) begin
            r = 1;
        end else begin
            r = $clog2(n);
        end
        return r;
    endfunction

    // Half an LSB of the output grid, added before the arithmetic shift (round half up).
    function automatic longint fir_round_half(input int frac);
        return 64'sd1 <<< (frac - 1);
    endfunction

    localparam longint ROUND_HALF = fir_round_half(FIR_FRAC);

    // Sign-extend a full-precision product into the accumulator width.
    function automatic logic signed [FIR_ACC_W-1:0] sext_prod(
        input logic signed [FIR_PROD_W-1:0] p
    );
        return {{(FIR_ACC_W - FIR_PROD_W){p[FIR_PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/fir_sparse_tdm_q15_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC and saturation to OUT_W.
// The sum is formed one bit wider than the accumulator so the rounding offset
// can never wrap a large positive accumulator into a negative result.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = FIR_ACC_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int FRAC  = FIR_FRAC
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    sat_o
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] HALF_S = SUM_W'(fir_round_half(FRAC));
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] MIN_S  = ~MAX_S;

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] shr_s;

    // Round, shift, then clip into the signed OUT_W range and flag any clipping.
    always_comb begin
        sum_s = {acc_i[ACC_W-1], acc_i} + HALF_S;
        shr_s = sum_s >>> FRAC;
        if (shr_s > MAX_S) begin
            out_o = MAX_S[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (shr_s < MIN_S) begin
            out_o = MIN_S[OUT_W-1:0];
            sat_o = 1'b1;
        end else begin
            out_o = shr_s[OUT_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/fir_sparse_tdm_q15.sv
// Pruned Q15 FIR shared by CH time-multiplexed channels. Each channel owns a
// circular delay line of L samples; all channels share one sparse table of NZ
// (tap, coefficient) entries and a single MAC that walks the table one entry
// per cycle. Results are rounded/saturated and handed off with valid/ready.
module fir_sparse_tdm_q15
    import fir_pkg::*;
#(
    parameter  int L      = FIR_L,
    parameter  int NZ     = FIR_NZ,
    parameter  int CH     = FIR_CH,
    parameter  int IN_W   = FIR_IN_W,
    parameter  int COEF_W = FIR_COEF_W,
    parameter  int ACC_W  = FIR_ACC_W,
    parameter  int OUT_W  = FIR_OUT_W,
    parameter  int FRAC   = FIR_FRAC,
    localparam int CH_W   = fir_clog2(CH),
    localparam int ADDR_W = fir_clog2(NZ),
    localparam int TAP_W  = fir_clog2(L)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   data_in,
    input  logic [CH_W-1:0]          data_in_ch,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic signed [OUT_W-1:0]  data_out,
    output logic [CH_W-1:0]          data_out_ch,
    output logic                     data_out_sat,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [TAP_W-1:0]         cfg_tap,
    input  logic signed [COEF_W-1:0] cfg_coef,
    output logic                     cfg_err
);

    localparam int PROD_W = IN_W + COEF_W;

    // Controller state
    fir_state_e              state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [ADDR_W-1:0]       k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [TAP_W-1:0]        newest_q, newest_d;

    // Storage: per-channel delay lines and write pointers, shared sparse table
    logic signed [IN_W-1:0]   dline_q  [CH][L];
    logic [TAP_W-1:0]         wr_ptr_q [CH];
    logic [TAP_W-1:0]         tap_q    [NZ];
    logic signed [COEF_W-1:0] coef_q   [NZ];

    // Registered outputs
    logic signed [OUT_W-1:0] dout_q, dout_d;
    logic [CH_W-1:0]         dout_ch_q, dout_ch_d;
    logic                    dout_sat_q, dout_sat_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    din_ready_q, din_ready_d;
    logic                    cfg_err_q, cfg_err_d;

    // Combinational helpers
    logic                     ch_ok_s;
    logic                     accept_s;
    logic                     cfg_ok_s;
    logic                     cfg_wr_s;
    logic [TAP_W-1:0]         cur_ptr_s;
    logic [TAP_W-1:0]         next_ptr_s;
    logic [TAP_W-1:0]         tap_s;
    logic [TAP_W-1:0]         rd_idx_s;
    logic signed [IN_W-1:0]   x_s;
    logic signed [COEF_W-1:0] c_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [OUT_W-1:0]  rs_out_s;
    logic                     rs_sat_s;

    assign data_in_ready  = din_ready_q;
    assign data_out       = dout_q;
    assign data_out_ch    = dout_ch_q;
    assign data_out_sat   = dout_sat_q;
    assign data_out_valid = dout_valid_q;
    assign cfg_err        = cfg_err_q;

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .FRAC  (FRAC)
    ) u_round_sat (
        .acc_i (acc_q),
        .out_o (rs_out_s),
        .sat_o (rs_sat_s)
    );

    // Write-pointer lookup and modulo-L advance for the channel being offered.
    always_comb begin
        ch_ok_s   = (int'(data_in_ch) < CH);
        cur_ptr_s = wr_ptr_q[data_in_ch];
        if (cur_ptr_s == TAP_W'(L - 1)) begin
            next_ptr_s = {TAP_W{1'b0}};
        end else begin
            next_ptr_s = cur_ptr_s + TAP_W'(1);
        end
    end

    // MAC operand fetch: sample that is tap[k] older than the newest one, modulo L.
    always_comb begin
        tap_s = tap_q[k_q];
        if (newest_q >= tap_s) begin
            rd_idx_s = newest_q - tap_s;
        end else begin
            rd_idx_s = newest_q + TAP_W'(L) - tap_s;
        end
        x_s    = dline_q[ch_q][rd_idx_s];
        c_s    = coef_q[k_q];
        prod_s = PROD_W'(x_s) * PROD_W'(c_s);
    end

    // Table writes are only honoured in IDLE with an in-range entry and tap.
    always_comb begin
        cfg_ok_s = (int'(cfg_addr) < NZ) && (int'(cfg_tap) < L);
        if (cfg_we && (state_q == IDLE) && cfg_ok_s) begin
            cfg_wr_s  = 1'b1;
            cfg_err_d = 1'b0;
        end else if (cfg_we) begin
            cfg_wr_s  = 1'b0;
            cfg_err_d = 1'b1;
        end else begin
            cfg_wr_s  = 1'b0;
            cfg_err_d = 1'b0;
        end
    end

    // Next-state and output logic for the accept / MAC / round / hand-off sequence.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        k_d          = k_q;
        acc_d        = acc_q;
        newest_d     = newest_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_sat_d   = dout_sat_q;
        dout_valid_d = dout_valid_q;
        accept_s     = 1'b0;
        case (state_q)
            IDLE: begin
                // Samples addressed to a non-existent channel are silently dropped.
                if (data_in_valid && ch_ok_s) begin
                    accept_s = 1'b1;
                    ch_d     = data_in_ch;
                    newest_d = cur_ptr_s;
                    acc_d    = {ACC_W{1'b0}};
                    k_d      = {ADDR_W{1'b0}};
                    state_d  = MAC;
                end else begin
                    state_d  = IDLE;
                end
            end
            MAC: begin
                acc_d = acc_q + sext_prod(prod_s);
                if (k_q == ADDR_W'(NZ - 1)) begin
                    k_d     = {ADDR_W{1'b0}};
                    state_d = ROUND;
                end else begin
                    k_d     = k_q + ADDR_W'(1);
                    state_d = MAC;
                end
            end
            ROUND: begin
                dout_d       = rs_out_s;
                dout_ch_d    = ch_q;
                dout_sat_d   = rs_sat_s;
                dout_valid_d = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                // A sample offered during the hand-off cycle waits for IDLE.
                if (data_out_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d      = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        din_ready_d = (state_d == IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= {CH_W{1'b0}};
            k_q          <= {ADDR_W{1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            newest_q     <= {TAP_W{1'b0}};
            dout_q       <= {OUT_W{1'b0}};
            dout_ch_q    <= {CH_W{1'b0}};
            dout_sat_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            newest_q     <= newest_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_sat_q   <= dout_sat_d;
            dout_valid_q <= dout_valid_d;
            din_ready_q  <= din_ready_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Delay-line, write-pointer and coefficient-table storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                wr_ptr_q[c] <= {TAP_W{1'b0}};
                for (int i = 0; i < L; i++) begin
                    dline_q[c][i] <= {IN_W{1'b0}};
                end
            end
            for (int e = 0; e < NZ; e++) begin
                tap_q[e]  <= {TAP_W{1'b0}};
                coef_q[e] <= {COEF_W{1'b0}};
            end
        end else begin
            if (accept_s) begin
                dline_q[data_in_ch][cur_ptr_s] <= data_in;
                wr_ptr_q[data_in_ch]           <= next_ptr_s;
            end
            if (cfg_wr_s) begin
                tap_q[cfg_addr]  <= cfg_tap;
                coef_q[cfg_addr] <= cfg_coef;
            end
        end
    end

endmodule

// File: tb/tb_fir_sparse_tdm_q15.sv
// Directed bench for fir_sparse_tdm_q15 with hand-computed expected results.
module tb_fir_sparse_tdm_q15;

    localparam int LAT = 25;   // accept edge to data_out_valid, NZ+1 with NZ=24

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_in_ch;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [15:0] data_out;
    logic        data_out_ch;
    logic        data_out_sat;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [4:0]  cfg_tap;
    logic [15:0] cfg_coef;
    logic        cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    fir_sparse_tdm_q15 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_ch     (data_in_ch),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_ch    (data_out_ch),
        .data_out_sat   (data_out_sat),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_tap        (cfg_tap),
        .cfg_coef       (cfg_coef),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_we         = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        rst_n          = 1'b0;
        tick();
        tick();
        rst_n          = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (data_in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (data_in_ready !== 1'b1) check_eq("idle_timeout", 32'(data_in_ready), 32'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (data_out_valid !== 1'b1 && lat < 100);
    endtask

    task automatic send_sample(input logic ch, input logic [15:0] din,
                               input logic [15:0] exp_v, input logic exp_sat,
                               input string tag);
        int lat;
        wait_idle();
        data_in_ch    = ch;
        data_in       = din;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        wait_valid(lat);
        check_eq({tag, "_lat"},  32'(lat),          32'(LAT));
        check_eq({tag, "_dout"}, 32'(data_out),     32'(exp_v));
        check_eq({tag, "_sat"},  32'(data_out_sat), 32'(exp_sat));
        check_eq({tag, "_ch"},   32'(data_out_ch),  32'(ch));
        tick();
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [4:0] tap,
                             input logic [15:0] coef, input logic exp_err,
                             input string tag);
        wait_idle();
        cfg_addr = addr;
        cfg_tap  = tap;
        cfg_coef = coef;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        check_eq({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
        tick();
        check_eq({tag, "_err_clr"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic seen;
        logic [15:0] din;
        logic [15:0] exp_v;

        rst_n          = 1'b0;
        data_in        = 16'h0000;
        data_in_ch     = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        cfg_we         = 1'b0;
        cfg_addr       = 5'd0;
        cfg_tap        = 5'd0;
        cfg_coef       = 16'h0000;
        tick();
        tick();
        check_eq("rst_dout",   32'(data_out),       32'd0);
        check_eq("rst_valid",  32'(data_out_valid), 32'd0);
        check_eq("rst_sat",    32'(data_out_sat),   32'd0);
        check_eq("rst_ch",     32'(data_out_ch),    32'd0);
        check_eq("rst_ready",  32'(data_in_ready),  32'd1);
        check_eq("rst_cfgerr", 32'(cfg_err),        32'd0);
        rst_n = 1'b1;
        tick();

        // Impulse through tap 0, then a zero, then a duplicate tap-0 entry
        cfg_write(5'd0, 5'd0, 16'h7FFF, 1'b0, "cfg_imp");
        send_sample(1'b0, 16'h4000, 16'd16384, 1'b0, "imp1");
        send_sample(1'b0, 16'h0000, 16'd0,     1'b0, "imp0");
        cfg_write(5'd1, 5'd0, 16'h7FFF, 1'b0, "cfg_dup");
        send_sample(1'b0, 16'h2000, 16'd16384, 1'b0, "dup");

        // Longest delay and pointer wrap
        do_reset();
        cfg_write(5'd0, 5'd30, 16'h7FFF, 1'b0, "cfg_dly");
        for (int i = 0; i < 62; i++) begin
            din   = (i == 0) ? 16'h4000 : ((i == 31) ? 16'h2000 : 16'h0000);
            exp_v = (i == 30) ? 16'd16384 : ((i == 61) ? 16'd8192 : 16'd0);
            send_sample(1'b0, din, exp_v, 1'b0, $sformatf("dly%0d", i));
        end

        // Rounding, positive and negative saturation
        do_reset();
        cfg_write(5'd0, 5'd0, 16'h7FFF, 1'b0, "cfg_sat0");
        cfg_write(5'd1, 5'd1, 16'h7FFF, 1'b0, "cfg_sat1");
        send_sample(1'b0, 16'h7FFF, 16'h7FFE, 1'b0, "pos1");
        send_sample(1'b0, 16'h7FFF, 16'h7FFF, 1'b1, "pos2");
        send_sample(1'b0, 16'h8000, 16'hFFFF, 1'b0, "neg1");
        send_sample(1'b0, 16'h8000, 16'h8000, 1'b1, "neg2");

        // Channel isolation (tap 1 must see only the own channel's history)
        do_reset();
        cfg_write(5'd0, 5'd0, 16'h7FFF, 1'b0, "cfg_ch0");
        cfg_write(5'd1, 5'd1, 16'h7FFF, 1'b0, "cfg_ch1");
        send_sample(1'b0, 16'h4000, 16'd16384, 1'b0, "chA0");
        send_sample(1'b1, 16'h2000, 16'd8192,  1'b0, "chB0");
        send_sample(1'b0, 16'h0000, 16'd16384, 1'b0, "chA1");
        send_sample(1'b1, 16'h0000, 16'd8192,  1'b0, "chB1");

        // Backpressure: result held, next sample waits for the hand-off
        data_out_ready = 1'b0;
        wait_idle();
        data_in_ch    = 1'b0;
        data_in       = 16'h1000;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        wait_valid(lat);
        check_eq("bp_lat",  32'(lat),      32'(LAT));
        check_eq("bp_dout", 32'(data_out), 32'd4096);
        data_in_ch    = 1'b1;
        data_in       = 16'h0800;
        data_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("bp_hold_valid%0d", i), 32'(data_out_valid), 32'd1);
            check_eq($sformatf("bp_hold_dout%0d", i),  32'(data_out),       32'd4096);
            check_eq($sformatf("bp_hold_rdy%0d", i),   32'(data_in_ready),  32'd0);
        end
        data_out_ready = 1'b1;
        tick();
        check_eq("bp_hs_valid", 32'(data_out_valid), 32'd0);
        check_eq("bp_hs_rdy",   32'(data_in_ready),  32'd1);
        tick();
        check_eq("bp_acc_rdy",  32'(data_in_ready),  32'd0);
        data_in_valid = 1'b0;
        wait_valid(lat);
        check_eq("bp2_lat",  32'(lat),         32'(LAT));
        check_eq("bp2_dout", 32'(data_out),    32'd2048);
        check_eq("bp2_ch",   32'(data_out_ch), 32'd1);
        tick();

        // Rejected configuration writes leave the table untouched
        do_reset();
        cfg_write(5'd0, 5'd0,  16'h7FFF, 1'b0, "cfg_err0");
        cfg_write(5'd0, 5'd31, 16'h1234, 1'b1, "cfg_tap31");
        cfg_write(5'd24, 5'd0, 16'h1234, 1'b1, "cfg_addr24");
        wait_idle();
        data_in_ch    = 1'b0;
        data_in       = 16'h4000;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        tick();
        tick();
        tick();
        cfg_addr = 5'd0;
        cfg_tap  = 5'd0;
        cfg_coef = 16'h1234;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        check_eq("cfg_mac_err", 32'(cfg_err), 32'd1);
        wait_valid(lat);
        check_eq("cfg_mac_dout", 32'(data_out), 32'd16384);
        tick();
        send_sample(1'b0, 16'h4000, 16'd16384, 1'b0, "tbl_kept");

        // Table write and sample accept in the same IDLE cycle
        wait_idle();
        cfg_addr      = 5'd0;
        cfg_tap       = 5'd0;
        cfg_coef      = 16'h4000;
        cfg_we        = 1'b1;
        data_in_ch    = 1'b1;
        data_in       = 16'h4000;
        data_in_valid = 1'b1;
        tick();
        cfg_we        = 1'b0;
        data_in_valid = 1'b0;
        check_eq("same_cyc_err", 32'(cfg_err), 32'd0);
        wait_valid(lat);
        check_eq("same_cyc_lat",  32'(lat),         32'(LAT));
        check_eq("same_cyc_dout", 32'(data_out),    32'd8192);
        check_eq("same_cyc_ch",   32'(data_out_ch), 32'd1);
        tick();

        // Reset in the middle of a MAC sweep
        wait_idle();
        data_in_ch    = 1'b0;
        data_in       = 16'h4000;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        check_eq("mrst_dout",  32'(data_out),       32'd0);
        check_eq("mrst_ch",    32'(data_out_ch),    32'd0);
        check_eq("mrst_valid", 32'(data_out_valid), 32'd0);
        check_eq("mrst_sat",   32'(data_out_sat),   32'd0);
        check_eq("mrst_ready", 32'(data_in_ready),  32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | data_out_valid;
        end
        check_eq("mrst_no_out", 32'(seen), 32'd0);
        send_sample(1'b0, 16'h4000, 16'd0, 1'b0, "mrst_tbl_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
